// File: rtl/rom_arbiter.sv
// Two-port round-robin burst arbiter in front of a single-port synchronous ROM.
// A granted port receives N consecutive bytes, with the address counter wrapping at the top of the ROM.
module rom_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] base0,
  input  logic [ADDR_WIDTH-1:0] base1,
  input  logic [LEN_WIDTH-1:0]  len0,
  input  logic [LEN_WIDTH-1:0]  len1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  vld0,
  output logic                  vld1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    TAIL  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  port_reg, port_next;
  logic                  last_reg, last_next;
  logic                  first_reg, first_next;
  logic [LEN_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;

  logic [1:0]            req_vec;
  logic [ADDR_WIDTH-1:0] base_arr [2];
  logic [LEN_WIDTH-1:0]  len_arr  [2];
  logic [1:0]            gnt_vec;
  logic [1:0]            vld_vec;
  logic [1:0]            done_vec;
  logic                  winner;
  logic                  beat_phase;

  assign req_vec     = {req1, req0};
  assign base_arr[0] = base0;
  assign base_arr[1] = base1;
  assign len_arr[0]  = len0;
  assign len_arr[1]  = len1;

  // On a tie the port that was not served last wins.
  always_comb begin
    winner = 1'b0;
    if (req_vec == 2'b11) begin
      winner = ~last_reg;
    end else begin
      winner = req_vec[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      port_reg  <= 1'b0;
      last_reg  <= 1'b1;
      first_reg <= 1'b0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      port_reg  <= port_next;
      last_reg  <= last_next;
      first_reg <= first_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
    end
  end

  // cnt holds the number of addresses still to issue after the current one;
  // len = 0 naturally becomes 2^LEN_WIDTH - 1 through the wrapping subtract.
  always_comb begin
    state_next = state_reg;
    port_next  = port_reg;
    last_next  = last_reg;
    first_next = 1'b0;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (req_vec != 2'b00) begin
          state_next = BURST;
          port_next  = winner;
          last_next  = winner;
          first_next = 1'b1;
          addr_next  = base_arr[winner];
          cnt_next   = len_arr[winner] - LEN_WIDTH'(1);
        end
      end
      BURST: begin
        if (cnt_reg == '0) begin
          state_next = TAIL;
        end else begin
          addr_next = addr_reg + ADDR_WIDTH'(1);
          cnt_next  = cnt_reg - LEN_WIDTH'(1);
        end
      end
      TAIL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Data returns one cycle behind each issued address, so every BURST cycle
  // except the first plus the TAIL cycle carries a byte.
  assign beat_phase = ((state_reg == BURST) && !first_reg) || (state_reg == TAIL);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT_ID = 1'(gi);
      assign gnt_vec[gi]  = (state_reg == BURST) && first_reg && (port_reg == PORT_ID);
      assign vld_vec[gi]  = beat_phase && (port_reg == PORT_ID);
      assign done_vec[gi] = (state_reg == TAIL) && (port_reg == PORT_ID);
    end
  endgenerate

  assign gnt0     = gnt_vec[0];
  assign gnt1     = gnt_vec[1];
  assign vld0     = vld_vec[0];
  assign vld1     = vld_vec[1];
  assign done0    = done_vec[0];
  assign done1    = done_vec[1];
  assign dout     = rom_q;
  assign rom_addr = addr_reg;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: expected grants and data beats are queued
// when a burst is requested and consumed by a monitor as the DUT produces them.
module tb_rom_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [AW-1:0] base0, base1;
  logic [LW-1:0] len0, len1;
  logic          gnt0, gnt1, vld0, vld1, done0, done1;
  logic [DW-1:0] dout;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  bit    gnt_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  bit    mon_en   = 1'b0;

  rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .base0(base0), .base1(base1),
    .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1),
    .vld0(vld0), .vld1(vld1),
    .done0(done0), .done1(done1),
    .dout(dout), .rom_addr(rom_addr), .rom_q(rom_q)
  );

  always #10 clk = ~clk;

  // ROM model: mem[i] = i[7:0], one-cycle registered read
  always @(posedge clk) rom_q <= rom_addr[7:0];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      check("gnt_excl", gnt0 & gnt1, 0);
      if (gnt0 | gnt1) begin
        if (gnt_q.size() == 0) check("gnt_unexp", {gnt1, gnt0}, 0);
        else begin
          bit p;
          p = gnt_q.pop_front();
          check("gnt_port", {gnt1, gnt0}, p ? 2 : 1);
        end
      end
      if (vld0 | vld1) begin
        if (exp_q.size() == 0) check("vld_unexp", {vld1, vld0}, 0);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          check("vld_port", {vld1, vld0}, b.port ? 2 : 1);
          check("dout", dout, b.data);
          check("done", {done1, done0}, b.last ? (b.port ? 2 : 1) : 0);
        end
      end else begin
        check("done_idle", {done1, done0}, 0);
      end
    end
  end

  task automatic push_burst(bit p, logic [AW-1:0] b, logic [LW-1:0] l);
    int n;
    logic [AW-1:0] a;
    beat_t bt;
    n = (l == 0) ? (1 << LW) : int'(l);
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      bt.port = p;
      bt.data = a[7:0];
      bt.last = (i == n - 1);
      exp_q.push_back(bt);
    end
    gnt_q.push_back(p);
    $display("burst port %0d base 0x%0h len %0d queued", p, b, n);
  endtask

  task automatic set_port(bit p, logic [AW-1:0] b, logic [LW-1:0] l, logic r);
    if (p) begin base1 = b; len1 = l; req1 = r; end
    else   begin base0 = b; len0 = l; req0 = r; end
  endtask

  task automatic wait_gnt(bit p, output int at);
    bit found;
    found = 1'b0;
    at = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk); #1;
      if ((p ? gnt1 : gnt0) === 1'b1) begin found = 1'b1; at = cyc; end
    end
    check(p ? "gnt1_seen" : "gnt0_seen", found, 1);
  endtask

  task automatic wait_drain(int limit);
    for (int k = 0; k < limit && (exp_q.size() != 0 || gnt_q.size() != 0); k++) begin
      @(negedge clk); #2;
    end
    check("drain_beats", exp_q.size(), 0);
    check("drain_gnts", gnt_q.size(), 0);
    @(negedge clk); #2;
  endtask

  // Single burst; also checks the first few issued addresses, including wrap.
  task automatic run_burst(bit p, logic [AW-1:0] b, logic [LW-1:0] l);
    int at, n;
    logic [AW-1:0] a;
    n = (l == 0) ? (1 << LW) : int'(l);
    push_burst(p, b, l);
    @(posedge clk); #1;
    set_port(p, b, l, 1'b1);
    wait_gnt(p, at);
    set_port(p, b, l, 1'b0);
    for (int i = 0; i < 4 && i < n; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      a = b + AW'(i);
      check("rom_addr", rom_addr, a);
    end
    wait_drain(n + 20);
  endtask

  initial begin
    int ca, cb, cc, beats;
    logic [6:0] g_pat, v_pat, d_pat;
    rst = 1'b1; req0 = 0; req1 = 0;
    base0 = '0; base1 = '0; len0 = '0; len1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_addr", rom_addr, 0);
    check("rst_outs", {gnt1, gnt0, vld1, vld0, done1, done0}, 0);
    mon_en = 1'b1;

    // Directed timing: gnt cycle 1, vld cycles 2-5, done cycle 5
    push_burst(0, 15'h0100, 10'd4);
    @(posedge clk); #1;
    set_port(0, 15'h0100, 10'd4, 1'b1);
    g_pat = '0; v_pat = '0; d_pat = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); #1;
      g_pat[k] = gnt0; v_pat[k] = vld0; d_pat[k] = done0;
      if (k == 1) req0 = 1'b0;
    end
    check("t1_gnt_pat", g_pat, 7'b0000010);
    check("t1_vld_pat", v_pat, 7'b0111100);
    check("t1_done_pat", d_pat, 7'b0100000);
    wait_drain(10);

    // Address wrap at the top of the ROM
    run_burst(1, 15'h7FFE, 10'd4);

    // len = 0 means 1024 beats
    run_burst(0, 15'h0123, 10'd0);

    // Reset on the third data beat of an 8-beat burst
    push_burst(0, 15'h0200, 10'd8);
    @(posedge clk); #1;
    set_port(0, 15'h0200, 10'd8, 1'b1);
    wait_gnt(0, ca);
    req0 = 1'b0;
    beats = 0;
    for (int k = 0; k < 20 && beats < 3; k++) begin
      @(negedge clk); #2;
      if (vld0) beats++;
    end
    check("rst_beats_seen", beats, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk); #1;
    check("abort_addr", rom_addr, 0);
    check("abort_outs", {gnt1, gnt0, vld1, vld0, done1, done0}, 0);
    repeat (8) @(negedge clk);
    run_burst(0, 15'h0240, 10'd3);

    // Tie after reset: port 0 first; with req0 held, next tie goes to port 1
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push_burst(0, 15'h0020, 10'd2);
    push_burst(1, 15'h0040, 10'd2);
    push_burst(0, 15'h0020, 10'd2);
    set_port(0, 15'h0020, 10'd2, 1'b1);
    set_port(1, 15'h0040, 10'd2, 1'b1);
    wait_gnt(0, ca);
    wait_gnt(1, cb);
    req1 = 1'b0;
    wait_gnt(0, cc);
    req0 = 1'b0;
    check("tie_gap_a", cb - ca, 4);
    check("tie_gap_b", cc - cb, 4);
    wait_drain(20);

    // req1 raised and req0 dropped mid-burst; base0/len0 disturbed after grant
    push_burst(0, 15'h0300, 10'd6);
    push_burst(1, 15'h0310, 10'd2);
    @(posedge clk); #1;
    set_port(0, 15'h0300, 10'd6, 1'b1);
    wait_gnt(0, ca);
    set_port(1, 15'h0310, 10'd2, 1'b1);
    @(negedge clk); #1;
    set_port(0, 15'h5555, 10'd1, 1'b0);
    wait_gnt(1, cb);
    req1 = 1'b0;
    check("mid_gap", cb - ca, 8);
    wait_drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
